gcd_controller: RTL and testbench
=================================

GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 Parameter op_sz, default 8, operand width (shared with the GCD datapath).
REQ-002 Parameter CNT_W, default 9, iteration counter width.
REQ-003 Parameter MAX_ITER, default 256, subtraction limit before timeout; SHALL be >= 2^op_sz - 2 and < 2^CNT_W.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand pair on datapath A/B inputs is valid.
REQ-007 in_ready  output  1  controller can accept operands.
REQ-008 abort  input  1  cancel the computation in progress.
REQ-009 A_eq_B  input  1  datapath flag, reg_A == reg_B.
REQ-010 A_gt_B  input  1  datapath flag, reg_A > reg_B.
REQ-011 A_sel, B_sel  output  1 each  datapath mux selects; 0 = external operand, 1 = difference.
REQ-012 A_ld, B_ld, out_ld  output  1 each  datapath register load enables.
REQ-013 out_valid  output  1  datapath res holds a completed result.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 err  output  1  completed result is a timeout (invalid GCD).
REQ-016 iter_cnt  output  CNT_W  subtractions performed in the current or last operation.

Function
REQ-017 States: IDLE, CALC, DONE; state register is the only sequential control, plus iter_cnt and err.
REQ-018 A_sel, B_sel, A_ld, B_ld, out_ld SHALL be combinational functions of state and inputs (Mealy), and 0 unless stated below.
REQ-019 IDLE: in_ready=1; on in_valid: A_sel=0, B_sel=0, A_ld=1, B_ld=1, iter_cnt<=0, err<=0, next CALC.
REQ-020 CALC, priority order: abort -> no loads, next IDLE; A_eq_B -> out_ld=1, next DONE; iter_cnt==MAX_ITER -> out_ld=1, err<=1, next DONE; A_gt_B -> A_sel=1, A_ld=1, iter_cnt+1; else -> B_sel=1, B_ld=1, iter_cnt+1.
REQ-021 in_ready SHALL be 0 in CALC and DONE; in_valid there SHALL be ignored.
REQ-022 DONE: out_valid=1; err stable; on out_ready: next IDLE; abort ignored in DONE.
REQ-023 Latency: out_valid first asserts N+3 cycles after the accepting edge-cycle, N = subtraction count.
REQ-024 iter_cnt SHALL never wrap; it saturates at MAX_ITER via the timeout rule.
REQ-025 Zero operand (one side 0, other non-zero) SHALL terminate via timeout with err=1; both zero SHALL complete with res=0, err=0, iter_cnt=0.
REQ-026 in_valid and out_ready together in DONE: out_ready handled, in_valid not accepted until IDLE.

Reset
REQ-027 rst low SHALL force IDLE immediately, independent of clk: in_ready=1; out_valid, err, all load/select outputs 0; iter_cnt=0.
REQ-028 Reset mid-CALC or mid-DONE SHALL discard the operation; no out_ld after release.
REQ-029 First in_valid accepted on the first rising edge with rst high.

Verification
REQ-030 A=12, B=8 -> loads, A-sub, B-sub, out_ld; out_valid 5 cycles after accept, res=4, iter_cnt=2, err=0.
REQ-031 A=255, B=1 -> res=1, iter_cnt=254, err=0; A=7, B=7 -> res=7, iter_cnt=0.
REQ-032 A=0, B=5 -> iter_cnt reaches 256, out_valid with err=1.
REQ-033 Hold out_ready low 10 cycles in DONE, pulse in_valid -> out_valid and res stable, in_ready=0, no loads.
REQ-034 Assert abort during CALC of A=200, B=3 -> IDLE next cycle, out_ld never asserts, new operands then accepted.
REQ-035 Drop rst asynchronously mid-CALC -> outputs reach reset values before next clk edge; next operation A=18, B=24 -> res=6.

Source files
------------

// File: rtl/gcd_controller_if.sv
// ---------------------------------------------------------------------------
// gcd_controller_if
// Groups the control and handshake signals between the GCD controller and
// its surroundings: the producer and consumer handshakes and the datapath
// flags and controls.
//
// Signals:
//   in_valid / in_ready   : operand handshake (environment -> controller)
//   out_valid / out_ready : result handshake (controller -> environment)
//   abort                 : cancels a computation in progress
//   A_eq_B, A_gt_B        : datapath compare flags
//   A_sel, B_sel          : datapath mux selects (0 external, 1 difference)
//   A_ld, B_ld, out_ld    : datapath register load enables
//   err                   : completed result is a timeout
//   iter_cnt              : subtraction count of current / last operation
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer may assert valid
// without waiting for ready. Once out_valid is high it stays high, and the
// result stays stable, until the edge where out_ready is seen.
//
// Modports:
//   master : the environment (operand source, result sink, datapath)
//   slave  : the controller
// ---------------------------------------------------------------------------
interface gcd_controller_if #(
    parameter int CNT_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic             A_eq_B;
    logic             A_gt_B;
    logic             A_sel;
    logic             B_sel;
    logic             A_ld;
    logic             B_ld;
    logic             out_ld;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic [CNT_W-1:0] iter_cnt;

    modport master (
        output in_valid, abort, A_eq_B, A_gt_B, out_ready,
        input  in_ready, A_sel, B_sel, A_ld, B_ld, out_ld, out_valid, err, iter_cnt
    );

    modport slave (
        input  in_valid, abort, A_eq_B, A_gt_B, out_ready,
        output in_ready, A_sel, B_sel, A_ld, B_ld, out_ld, out_valid, err, iter_cnt
    );
endinterface

// File: rtl/gcd_controller.sv
// ---------------------------------------------------------------------------
// gcd_controller
// Control FSM for a subtractive GCD datapath. The datapath holds reg_A and
// reg_B, reports A_eq_B / A_gt_B and loads them either from the external
// operands or from their difference. The controller steps the datapath one
// subtraction per cycle until the registers are equal, then loads the result
// register. An iteration limit (MAX_ITER) bounds the run so that a zero
// operand, which never converges, ends as a flagged timeout.
//
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset
//   ctl         : controller side of gcd_controller_if (see that file)
//   state_dbg_o : current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Parameters:
//   op_sz    : operand width of the datapath
//   CNT_W    : iteration counter width
//   MAX_ITER : subtraction limit; must be >= 2^op_sz - 2 and < 2^CNT_W
// ---------------------------------------------------------------------------
module gcd_controller #(
    parameter int op_sz    = 8,
    parameter int CNT_W    = 9,
    parameter int MAX_ITER = 256
) (
    input  logic                clk,
    input  logic                rst,
    gcd_controller_if.slave     ctl,
    output logic [1:0]          state_dbg_o
);

    // The limit must cover the worst-case legitimate run (2^op_sz-1 against
    // 1 needs 2^op_sz-2 subtractions) and must be representable in iter_cnt.
    if ((MAX_ITER < (2 ** op_sz) - 2) || (MAX_ITER >= (2 ** CNT_W))) begin : g_bad_param
        $error("gcd_controller: MAX_ITER out of range for op_sz/CNT_W");
    end

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
    logic             err_q, err_d;
    logic             in_ready_q;
    logic             out_valid_q;

    // Mealy controls before reset gating
    logic             a_sel_c, b_sel_c, a_ld_c, b_ld_c, out_ld_c;

    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        err_d      = err_q;
        a_sel_c    = 1'b0;
        b_sel_c    = 1'b0;
        a_ld_c     = 1'b0;
        b_ld_c     = 1'b0;
        out_ld_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ctl.in_valid) begin
                    a_ld_c     = 1'b1;
                    b_ld_c     = 1'b1;
                    iter_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = CALC;
                end
            end

            CALC: begin
                // Priority: abort, convergence, timeout, then one subtraction.
                // The limit is tested before incrementing, so the counter
                // stops at MAX_CNT and never wraps.
                if (ctl.abort) begin
                    state_d = IDLE;
                end else if (ctl.A_eq_B) begin
                    out_ld_c = 1'b1;
                    state_d  = DONE;
                end else if (iter_cnt_q == MAX_CNT) begin
                    out_ld_c = 1'b1;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else if (ctl.A_gt_B) begin
                    a_sel_c    = 1'b1;
                    a_ld_c     = 1'b1;
                    iter_cnt_d = iter_cnt_q + 1'b1;
                end else begin
                    b_sel_c    = 1'b1;
                    b_ld_c     = 1'b1;
                    iter_cnt_d = iter_cnt_q + 1'b1;
                end
            end

            DONE: begin
                // Result held until consumed; abort and in_valid have no
                // effect here.
                if (ctl.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            iter_cnt_q  <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_cnt_q  <= iter_cnt_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    // While rst is low the state is already IDLE, but an in_valid present
    // during reset would otherwise produce loads; gate every control.
    assign ctl.A_sel     = rst & a_sel_c;
    assign ctl.B_sel     = rst & b_sel_c;
    assign ctl.A_ld      = rst & a_ld_c;
    assign ctl.B_ld      = rst & b_ld_c;
    assign ctl.out_ld    = rst & out_ld_c;

    assign ctl.in_ready  = in_ready_q;
    assign ctl.out_valid = out_valid_q;
    assign ctl.err       = err_q;
    assign ctl.iter_cnt  = iter_cnt_q;

    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_gcd_controller.sv
// ---------------------------------------------------------------------------
// tb_gcd_controller
// Drives gcd_controller together with a behavioural GCD datapath and checks
// results, iteration counts, latency, handshakes, abort and reset behaviour
// against a plain-arithmetic reference.
// ---------------------------------------------------------------------------
module tb_gcd_controller;
    localparam int OP_SZ    = 8;
    localparam int CNT_W    = 9;
    localparam int MAX_ITER = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcd_controller_if #(.CNT_W(CNT_W)) bus ();
    logic [1:0] state_dbg;

    gcd_controller #(
        .op_sz    (OP_SZ),
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctl         (bus),
        .state_dbg_o (state_dbg)
    );

    // ---------------- datapath model ----------------
    logic [OP_SZ-1:0] a_in, b_in, reg_a, reg_b, res;

    always @(posedge clk) begin
        if (bus.A_ld) reg_a <= bus.A_sel ? reg_a - reg_b : a_in;
        if (bus.B_ld) reg_b <= bus.B_sel ? reg_b - reg_a : b_in;
        if (bus.out_ld) res <= reg_a;
    end

    assign bus.A_eq_B = (reg_a == reg_b);
    assign bus.A_gt_B = (reg_a > reg_b);

    // ---------------- control monitors ----------------
    int out_ld_n = 0;
    int a_sub_n  = 0;
    int b_sub_n  = 0;

    always @(negedge clk) begin
        if (bus.out_ld) out_ld_n++;
        if (bus.A_ld && bus.A_sel) a_sub_n++;
        if (bus.B_ld && bus.B_sel) b_sub_n++;
    end

    // ---------------- scoreboard ----------------
    logic [OP_SZ-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int last_cnt;
    int last_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: repeated subtraction of the smaller from the larger value,
    // giving up after MAX_ITER subtractions.
    function automatic void ref_gcd(input int a, input int b, output int r, output int c,
                                    output bit e);
        c = 0;
        e = 1'b0;
        while (a != b) begin
            if (c == MAX_ITER) begin
                e = 1'b1;
                break;
            end
            if (a > b) a = a - b;
            else       b = b - a;
            c++;
        end
        r = a;
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic [OP_SZ-1:0] a, input logic [OP_SZ-1:0] b, input bit rel);
        int r, c, lat, a0, b0, o0;
        bit e;
        logic [OP_SZ-1:0] exp_r;
        ref_gcd(int'(a), int'(b), r, c, e);
        exp_q.push_back(r[OP_SZ-1:0]);
        a0 = a_sub_n;
        b0 = b_sub_n;
        o0 = out_ld_n;
        @(negedge clk);
        a_in = a;
        b_in = b;
        bus.in_valid = 1'b1;
        #1;
        check("accept_in_ready", bus.in_ready, 1);
        check("accept_controls", {bus.A_ld, bus.B_ld, bus.A_sel, bus.B_sel, bus.out_ld}, 5'b11000);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 2;
        while (!bus.out_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid", bus.out_valid, 1);
        check("latency", lat, c + 3);
        check("iter_cnt", bus.iter_cnt, c);
        check("err", bus.err, e);
        check("subtractions", (a_sub_n - a0) + (b_sub_n - b0), c);
        check("out_ld_once", out_ld_n - o0, 1);
        exp_r = exp_q.pop_front();
        if (!e) check("res", res, exp_r);
        last_cnt = c;
        last_res = r;
        if (rel) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
            check("release_handshake", {bus.in_ready, bus.out_valid}, 2'b10);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int o0;
        logic [OP_SZ-1:0] ra, rb;

        // Reset with in_valid high: no loads may leak out.
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        a_in          = 8'd5;
        b_in          = 8'd9;
        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_err", bus.err, 0);
        check("rst_iter_cnt", bus.iter_cnt, 0);
        check("rst_controls", {bus.A_ld, bus.B_ld, bus.A_sel, bus.B_sel, bus.out_ld}, 5'b0);

        // Release just after an edge; the first rising edge with rst high accepts.
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        run_op(8'd12, 8'd8, 1'b1);
        run_op(8'd255, 8'd1, 1'b1);
        run_op(8'd7, 8'd7, 1'b1);
        run_op(8'd0, 8'd5, 1'b1);
        check("zero_timeout_cnt", bus.iter_cnt, MAX_ITER);
        run_op(8'd5, 8'd0, 1'b1);
        run_op(8'd0, 8'd0, 1'b1);

        // Random operand pairs, occasionally with a zero side.
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(1, 255));
            rb = 8'($urandom_range(1, 255));
            if (i % 7 == 3) ra = 8'd0;
            run_op(ra, rb, 1'b1);
        end

        // DONE held for 10 cycles with an in_valid pulse in the middle.
        run_op(8'd36, 8'd24, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = (i == 4);
            #1;
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_controls", {bus.A_ld, bus.B_ld, bus.out_ld}, 3'b0);
            check("hold_res", res, last_res);
            check("hold_err", bus.err, 0);
        end
        // out_ready and in_valid together: only the release happens.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("both_controls", {bus.A_ld, bus.B_ld, bus.out_ld}, 3'b0);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("both_released", {bus.in_ready, bus.out_valid}, 2'b10);
        check("both_iter_kept", bus.iter_cnt, last_cnt);
        @(posedge clk);
        #1;
        check("both_not_accepted", bus.in_ready, 1);

        // Abort during a long computation.
        o0 = out_ld_n;
        @(negedge clk);
        a_in = 8'd200;
        b_in = 8'd3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        #1;
        check("abort_controls", {bus.A_ld, bus.B_ld, bus.out_ld}, 3'b0);
        @(posedge clk);
        #1 bus.abort = 1'b0;
        check("abort_idle", {bus.in_ready, bus.out_valid}, 2'b10);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_out_ld", out_ld_n - o0, 0);
        check("abort_still_idle", bus.in_ready, 1);
        run_op(8'd45, 8'd27, 1'b1);

        // Asynchronous reset in the middle of a calculation.
        @(negedge clk);
        a_in = 8'd255;
        b_in = 8'd2;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_err", bus.err, 0);
        check("arst_iter_cnt", bus.iter_cnt, 0);
        check("arst_controls", {bus.A_ld, bus.B_ld, bus.A_sel, bus.B_sel, bus.out_ld}, 5'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        o0 = out_ld_n;
        repeat (20) @(posedge clk);
        #1;
        check("arst_no_out_ld", out_ld_n - o0, 0);
        check("arst_idle", bus.in_ready, 1);
        run_op(8'd18, 8'd24, 1'b1);
        check("arst_next_res", res, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
